mwb_stage_reg: RTL and testbench

MWB_STAGE_REG -- requirements
Module: mwb_stage_reg

---
 rtl/mwb_stage_reg.sv | 85 ++++++++
 tb/tb_mwb_stage_reg.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mwb_stage_reg.sv
// mwb_stage_reg: MEM/WB pipeline register with stall, flush, writeback mux and retire counter.
// Ports: clk, rst_n (sync, active-low); stall holds the stage, flush loads a bubble (wins over stall);
// *_in / EXM_* capture into *_out / MWB_*; WB_Data = ReadData_out or ALU_Result_out by MemToReg_out;
// fwd_en = valid_out & RegWrite_out; retire_cnt counts departing valid instructions (saturating).
// CNT_RST sets the value retire_cnt takes on reset (0 normally).
module mwb_stage_reg #(
    parameter int          DATA_W  = 16,
    parameter int          REG_W   = 4,
    parameter int          OP_W    = 4,
    parameter int          ZERO_RO = 1,
    parameter logic [15:0] CNT_RST = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic              MemToReg_in,
    input  logic              RegWrite_in,
    input  logic [DATA_W-1:0] ALU_Result_in,
    input  logic [DATA_W-1:0] ReadData_in,
    input  logic [OP_W-1:0]   movOP_in,
    input  logic [REG_W-1:0]  EXM_RS,
    input  logic [REG_W-1:0]  EXM_RT,
    input  logic [REG_W-1:0]  EXM_RD,
    output logic              valid_out,
    output logic              MemToReg_out,
    output logic              RegWrite_out,
    output logic [DATA_W-1:0] ALU_Result_out,
    output logic [DATA_W-1:0] ReadData_out,
    output logic [OP_W-1:0]   movOP_out,
    output logic [REG_W-1:0]  MWB_RS,
    output logic [REG_W-1:0]  MWB_RT,
    output logic [REG_W-1:0]  MWB_RD,
    output logic [DATA_W-1:0] WB_Data,
    output logic              fwd_en,
    output logic [15:0]       retire_cnt
);
    logic rw_d;
    logic retire;
    // a write to register 0 is dropped here so forwarding never sees it
    assign rw_d   = RegWrite_in & valid_in & ((ZERO_RO == 0) || (EXM_RD != '0));
    // the held instruction leaves when the stage advances or is flushed out
    assign retire = valid_out & (~stall | flush);
    assign WB_Data = MemToReg_out ? ReadData_out : ALU_Result_out;
    assign fwd_en  = valid_out & RegWrite_out;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_out      <= 1'b0;
            MemToReg_out   <= 1'b0;
            RegWrite_out   <= 1'b0;
            ALU_Result_out <= '0;
            ReadData_out   <= '0;
            movOP_out      <= '0;
            MWB_RS         <= '0;
            MWB_RT         <= '0;
            MWB_RD         <= '0;
            retire_cnt     <= CNT_RST;
        end else begin
            if (retire && retire_cnt != 16'hFFFF)
                retire_cnt <= retire_cnt + 16'd1;
            if (flush) begin
                valid_out      <= 1'b0;
                MemToReg_out   <= 1'b0;
                RegWrite_out   <= 1'b0;
                ALU_Result_out <= '0;
                ReadData_out   <= '0;
                movOP_out      <= '0;
                MWB_RS         <= '0;
                MWB_RT         <= '0;
                MWB_RD         <= '0;
            end else if (!stall) begin
                valid_out      <= valid_in;
                MemToReg_out   <= MemToReg_in & valid_in;
                RegWrite_out   <= rw_d;
                ALU_Result_out <= ALU_Result_in;
                ReadData_out   <= ReadData_in;
                movOP_out      <= movOP_in;
                MWB_RS         <= EXM_RS;
                MWB_RT         <= EXM_RT;
                MWB_RD         <= EXM_RD;
            end
        end
    end
endmodule

// File: tb/tb_mwb_stage_reg.sv
// tb_mwb_stage_reg: directed checks of mwb_stage_reg (ZERO_RO=1 main, ZERO_RO=0 with preloaded counter).
module tb_mwb_stage_reg;
    logic        clk = 1'b0;
    logic        rst_n, stall, flush, valid_in, MemToReg_in, RegWrite_in;
    logic [15:0] ALU_Result_in, ReadData_in;
    logic [3:0]  movOP_in, EXM_RS, EXM_RT, EXM_RD;
    logic        valid_out, MemToReg_out, RegWrite_out, fwd_en;
    logic [15:0] ALU_Result_out, ReadData_out, WB_Data, retire_cnt;
    logic [3:0]  movOP_out, MWB_RS, MWB_RT, MWB_RD;
    logic        z_valid_out, z_MemToReg_out, z_RegWrite_out, z_fwd_en;
    logic [15:0] z_ALU_Result_out, z_ReadData_out, z_WB_Data, z_retire_cnt;
    logic [3:0]  z_movOP_out, z_MWB_RS, z_MWB_RT, z_MWB_RD;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mwb_stage_reg dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
        .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in), .ALU_Result_in(ALU_Result_in),
        .ReadData_in(ReadData_in), .movOP_in(movOP_in), .EXM_RS(EXM_RS), .EXM_RT(EXM_RT),
        .EXM_RD(EXM_RD), .valid_out(valid_out), .MemToReg_out(MemToReg_out),
        .RegWrite_out(RegWrite_out), .ALU_Result_out(ALU_Result_out), .ReadData_out(ReadData_out),
        .movOP_out(movOP_out), .MWB_RS(MWB_RS), .MWB_RT(MWB_RT), .MWB_RD(MWB_RD),
        .WB_Data(WB_Data), .fwd_en(fwd_en), .retire_cnt(retire_cnt)
    );

    mwb_stage_reg #(.ZERO_RO(0), .CNT_RST(16'hFFFE)) u_z (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
        .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in), .ALU_Result_in(ALU_Result_in),
        .ReadData_in(ReadData_in), .movOP_in(movOP_in), .EXM_RS(EXM_RS), .EXM_RT(EXM_RT),
        .EXM_RD(EXM_RD), .valid_out(z_valid_out), .MemToReg_out(z_MemToReg_out),
        .RegWrite_out(z_RegWrite_out), .ALU_Result_out(z_ALU_Result_out), .ReadData_out(z_ReadData_out),
        .movOP_out(z_movOP_out), .MWB_RS(z_MWB_RS), .MWB_RT(z_MWB_RT), .MWB_RD(z_MWB_RD),
        .WB_Data(z_WB_Data), .fwd_en(z_fwd_en), .retire_cnt(z_retire_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic mtr, input logic [15:0] alu,
                         input logic [15:0] rdd, input logic [3:0] op, input logic [3:0] rs,
                         input logic [3:0] rt, input logic [3:0] rd);
        valid_in = v; RegWrite_in = rw; MemToReg_in = mtr; ALU_Result_in = alu;
        ReadData_in = rdd; movOP_in = op; EXM_RS = rs; EXM_RT = rt; EXM_RD = rd;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 16'h5A5A, 16'hA5A5, 4'h7, 4'h1, 4'h2, 4'h3);
        step();
        chk("rst_valid", valid_out, 0);
        chk("rst_wb", WB_Data, 0);
        chk("rst_alu", ALU_Result_out, 0);
        chk("rst_rd", MWB_RD, 0);
        chk("rst_fwd", fwd_en, 0);
        chk("rst_cnt", retire_cnt, 0);
        chk("rst_zcnt", z_retire_cnt, 16'hFFFE);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 16'h1111, 16'hBEEF, 4'h5, 4'h1, 4'h2, 4'h3);
        step();
        chk("pt_wb", WB_Data, 16'hBEEF);
        chk("pt_fwd", fwd_en, 1);
        chk("pt_rd", MWB_RD, 3);
        chk("pt_rs", MWB_RS, 1);
        chk("pt_rt", MWB_RT, 2);
        chk("pt_op", movOP_out, 5);
        chk("pt_alu", ALU_Result_out, 16'h1111);
        chk("pt_cnt", retire_cnt, 0);
        drive(1'b1, 1'b1, 1'b0, 16'h1234, 16'hCAFE, 4'h6, 4'h4, 4'h5, 4'h4);
        step();
        chk("alu_wb", WB_Data, 16'h1234);
        chk("alu_mtr", MemToReg_out, 0);
        chk("alu_cnt", retire_cnt, 1);
        chk("alu_zcnt", z_retire_cnt, 16'hFFFF);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 16'h5550 + 16'(i), 16'h0F00 + 16'(i), 4'(i), 4'(i), 4'(i), 4'(i + 8));
            step();
            chk("stall_alu", ALU_Result_out, 16'h1234);
            chk("stall_cnt", retire_cnt, 1);
        end
        chk("stall_rd", MWB_RD, 4);
        stall = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 16'h00AA, 16'h0000, 4'h1, 4'h0, 4'h0, 4'h0);
        step();
        chk("z_rw", RegWrite_out, 0);
        chk("z_fwd", fwd_en, 0);
        chk("z_alu", ALU_Result_out, 16'h00AA);
        chk("z_cnt", retire_cnt, 2);
        chk("z_rw_nro", z_RegWrite_out, 1);
        chk("z_fwd_nro", z_fwd_en, 1);
        chk("sat_cnt", z_retire_cnt, 16'hFFFF);
        drive(1'b1, 1'b1, 1'b1, 16'h2222, 16'h3333, 4'h9, 4'h1, 4'h2, 4'h5);
        step();
        stall = 1'b1; flush = 1'b1;
        step();
        chk("fl_valid", valid_out, 0);
        chk("fl_fwd", fwd_en, 0);
        chk("fl_rw", RegWrite_out, 0);
        chk("fl_mtr", MemToReg_out, 0);
        chk("fl_alu", ALU_Result_out, 0);
        chk("fl_rdd", ReadData_out, 0);
        chk("fl_op", movOP_out, 0);
        chk("fl_rd", MWB_RD, 0);
        chk("fl_cnt", retire_cnt, 4);
        chk("fl_zcnt", z_retire_cnt, 16'hFFFF);
        stall = 1'b0; flush = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 16'h4444, 16'h5555, 4'h2, 4'h1, 4'h2, 4'h6);
        step();
        chk("inv_valid", valid_out, 0);
        chk("inv_rw", RegWrite_out, 0);
        chk("inv_mtr", MemToReg_out, 0);
        chk("inv_cnt", retire_cnt, 4);
        drive(1'b1, 1'b1, 1'b0, 16'h7777, 16'h0000, 4'h3, 4'h1, 4'h2, 4'h7);
        step();
        chk("pre_rst_rd", MWB_RD, 7);
        stall = 1'b1; rst_n = 1'b0;
        step();
        chk("mrst_valid", valid_out, 0);
        chk("mrst_alu", ALU_Result_out, 0);
        chk("mrst_rd", MWB_RD, 0);
        chk("mrst_cnt", retire_cnt, 0);
        stall = 1'b0; rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 16'h9999, 16'h0001, 4'h4, 4'h2, 4'h3, 4'h9);
        step();
        chk("post_valid", valid_out, 1);
        chk("post_alu", ALU_Result_out, 16'h9999);
        chk("post_rd", MWB_RD, 9);
        chk("post_fwd", fwd_en, 1);
        chk("post_cnt", retire_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
